// File: rtl/mem_block_mover.sv
// Block-move engine: copies Len words from SrcAddr to DstAddr, or fills Len words
// at DstAddr with a constant, by mastering the data memory port while busy.
module mem_block_mover #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Mode,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  input  logic [W-1:0] FillValue,
  input  logic [W-1:0] MemRdData,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemWrData,
  output logic         Busy,
  output logic         Done,
  output logic [1:0]   dbg_state
);

  // Handshake: Start is a request pulse honoured only in IDLE (no queueing);
  // Busy covers the READ/WRITE cycles; Done pulses for one cycle at completion.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [A-1:0] ONE  = {{(A-1){1'b0}}, 1'b1};
  localparam logic [A-1:0] ZERO = '0;

  logic [1:0]   state;
  logic [A-1:0] src_ptr;
  logic [A-1:0] dst_ptr;
  logic [A-1:0] remaining;
  logic [W-1:0] buf_reg;
  logic [W-1:0] fill_reg;
  logic         mode_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      buf_reg   <= '0;
      fill_reg  <= '0;
      mode_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src_ptr   <= SrcAddr;
            dst_ptr   <= DstAddr;
            remaining <= Len;
            fill_reg  <= FillValue;
            mode_reg  <= Mode;
            if (Len == ZERO)
              state <= DONE;
            else if (Mode)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ: begin
          buf_reg <= MemRdData;
          src_ptr <= src_ptr + ONE;
          state   <= WRITE;
        end
        WRITE: begin
          dst_ptr   <= dst_ptr + ONE;
          remaining <= remaining - ONE;
          // Fill stays in WRITE back-to-back; copy alternates with READ.
          if (remaining == ONE)
            state <= DONE;
          else if (mode_reg)
            state <= WRITE;
          else
            state <= READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MemAddress = '0;
    case (state)
      READ:    MemAddress = src_ptr;
      WRITE:   MemAddress = dst_ptr;
      default: MemAddress = '0;
    endcase
  end

  // Reset gates the strobe combinationally so no write lands in a reset cycle.
  assign MemWriteEn = (state == WRITE) && !Reset;
  assign MemWrData  = mode_reg ? fill_reg : buf_reg;
  assign Busy       = (state == READ) || (state == WRITE);
  assign Done       = (state == DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural memory, table of transfers, write
// scoreboard, plus hand-written reset-in-flight sequence.
module tb_mem_block_mover;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Mode;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [7:0] Len;
  logic [7:0] FillValue;
  logic [7:0] MemRdData;
  logic       MemWriteEn;
  logic [7:0] MemAddress;
  logic [7:0] MemWrData;
  logic       Busy;
  logic       Done;
  logic [1:0] dbg_state;

  mem_block_mover #(.W(8), .A(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Mode      (Mode),
    .SrcAddr   (SrcAddr),
    .DstAddr   (DstAddr),
    .Len       (Len),
    .FillValue (FillValue),
    .MemRdData (MemRdData),
    .MemWriteEn(MemWriteEn),
    .MemAddress(MemAddress),
    .MemWrData (MemWrData),
    .Busy      (Busy),
    .Done      (Done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // behavioural memory: combinational read, write on rising edge
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  assign MemRdData = mem[MemAddress];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemWrData;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: {addr, data} of every expected write, popped as writes appear
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  always @(negedge Clk) begin
    if (MemWriteEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'h0, MemAddress, MemWrData}, 32'hffff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {24'h0, MemAddress}, {24'h0, mon_e[15:8]});
        check("write_data", {24'h0, MemWrData}, {24'h0, mon_e[7:0]});
      end
    end
  end

  typedef struct {
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill;
    int         exp_done;
    logic       repulse;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic run_xfer(input vec_t v);
    int c, busy_n, done_at;
    logic [7:0] s, d, w;
    s = v.src;
    d = v.dst;
    for (int k = 0; k < int'(v.len); k++) begin
      w = v.mode ? v.fill : ref_mem[s];
      ref_mem[d] = w;
      exp_q.push_back({d, w});
      s++;
      d++;
    end
    Mode = v.mode; SrcAddr = v.src; DstAddr = v.dst; Len = v.len; FillValue = v.fill;
    Start = 1'b1;
    step();
    Start = 1'b0;
    c = 1; busy_n = 0; done_at = 0;
    while (c <= 200 && done_at == 0) begin
      if (v.repulse && (c == 2 || c == 3)) begin
        Start = 1'b1; DstAddr = 8'd100; Mode = ~v.mode; Len = 8'd9;
      end else begin
        Start = 1'b0;
      end
      if (Done === 1'b1) begin
        done_at = c;
        check("busy_in_done", {31'h0, Busy}, 0);
        check("addr_in_done", {24'h0, MemAddress}, 0);
        check("we_in_done", {31'h0, MemWriteEn}, 0);
      end else if (Busy === 1'b1) begin
        busy_n++;
      end
      step();
      c++;
    end
    Start = 1'b0;
    check("done_cycle", done_at, v.exp_done);
    check("busy_cycles", busy_n, v.exp_done - 1);
    check("done_one_cycle", {31'h0, Done}, 0);
    check("writes_pending", exp_q.size(), 0);
    check_mem("mem_image");
  endtask

  initial begin
    int done_seen;
    logic [7:0] rl;
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0;
    SrcAddr = '0; DstAddr = '0; Len = '0; FillValue = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    ref_mem[16] = 8'd254; ref_mem[17] = 8'd1; ref_mem[18] = 8'd2; ref_mem[19] = 8'd3;
    ref_mem[4] = 8'd24;
    for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];

    rl = 8'($urandom_range(5, 30));
    //           mode  src     dst     len     fill    done       repulse
    vecs[0] = '{1'b0, 8'd16,  8'd32,  8'd4,   8'h00,  9,         1'b0};
    vecs[1] = '{1'b1, 8'd0,   8'd250, 8'd8,   8'hA5,  9,         1'b0};
    vecs[2] = '{1'b0, 8'd10,  8'd20,  8'd0,   8'h00,  1,         1'b0};
    vecs[3] = '{1'b1, 8'd0,   8'd30,  8'd0,   8'h77,  1,         1'b0};
    vecs[4] = '{1'b0, 8'd4,   8'd5,   8'd3,   8'h00,  7,         1'b0};
    vecs[5] = '{1'b0, 8'd16,  8'd40,  8'd2,   8'h00,  5,         1'b0};
    vecs[6] = '{1'b1, 8'd0,   8'd60,  8'd3,   8'h3C,  4,         1'b1};
    vecs[7] = '{1'b0, 8'd250, 8'd120, 8'd10,  8'h00,  21,        1'b0};
    vecs[8] = '{1'b1, 8'd0,   8'd200, rl,     8'($urandom_range(0, 255)), int'(rl) + 1, 1'b0};
    vecs[5].repulse = 1'b1;

    repeat (2) step();
    check("rst_busy", {31'h0, Busy}, 0);
    check("rst_done", {31'h0, Done}, 0);
    check("rst_we", {31'h0, MemWriteEn}, 0);
    check("rst_addr", {24'h0, MemAddress}, 0);
    check("rst_state", {30'h0, dbg_state}, 0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_xfer(vecs[i]);

    // reset during the second WRITE of a Len=4 copy: only the first word lands
    ref_mem[8'd70] = ref_mem[8'd16];
    exp_q.push_back({8'd70, ref_mem[8'd16]});
    Mode = 1'b0; SrcAddr = 8'd16; DstAddr = 8'd70; Len = 8'd4; FillValue = 8'h00;
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    #1;
    check("rst_we_gated", {31'h0, MemWriteEn}, 0);
    step();
    Reset = 1'b0;
    check("rst2_busy", {31'h0, Busy}, 0);
    check("rst2_done", {31'h0, Done}, 0);
    check("rst2_we", {31'h0, MemWriteEn}, 0);
    check("rst2_addr", {24'h0, MemAddress}, 0);
    check("rst2_state", {30'h0, dbg_state}, 0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done === 1'b1 || Busy === 1'b1) done_seen++;
      step();
    end
    check("rst2_no_done", done_seen, 0);
    check("rst2_pending", exp_q.size(), 0);
    check_mem("rst2_mem_image");

    // the engine must still work after an aborted transfer
    run_xfer(vecs[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
